// File: rtl/bin2bcd_resultado.sv
// Sequential 32-bit binary to 10-digit packed BCD converter (double dabble).
// Start/done handshake matches the shift-add multiplier so the two chain directly.
module bin2bcd_resultado #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [31:0] bin,
  output logic [39:0] bcd,
  output logic        sign,
  output logic        busy,
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADJ   = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [39:0] scratch_q, scratch_d;
  logic [4:0]  count_q, count_d;
  logic        neg_q, neg_d;
  logic [39:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic        neg_in;

  assign neg_in = SIGNED && bin[31];

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;

    case (state_q)
      S_IDLE: begin
        if (init) begin
          neg_d     = neg_in;
          shift_d   = neg_in ? (32'd0 - bin) : bin;
          scratch_d = '0;
          // 5-bit counter loaded with 0 stands for 32: it wraps to 31 on the first shift.
          count_d   = 5'd0;
          state_d   = S_ADJ;
        end
      end

      S_ADJ: begin
        for (int i = 0; i < 10; i++) begin
          if (scratch_q[4*i +: 4] >= 4'd5) begin
            scratch_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
          end
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        {scratch_d, shift_d} = {scratch_q[38:0], shift_q, 1'b0};
        count_d              = count_q - 5'd1;
        if (count_d == 5'd0) begin
          bcd_d   = {scratch_q[38:0], shift_q[31]};
          sign_d  = neg_q;
          state_d = S_FIN;
        end else begin
          state_d = S_ADJ;
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
    end
  end

  assign bcd  = bcd_q;
  assign sign = sign_q;
  assign busy = (state_q != S_IDLE);
  assign DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_bin2bcd_resultado.sv
// Scoreboard bench for bin2bcd_resultado: a signed and an unsigned instance
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_resultado;

  typedef struct {
    logic [39:0] bcd;
    logic        sign;
    int          acc_cyc;   // accepting cycle, -1 when latency is not checked
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_s = 1'b0, init_u = 1'b0;
  logic [31:0] bin_s = '0, bin_u = '0;
  logic [39:0] bcd_s, bcd_u;
  logic        sign_s, sign_u, busy_s, busy_u, done_s, done_u;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt_s = 0;
  bit busy_chk_s = 0, busy_chk_u = 0;
  exp_t q_s[$], q_u[$];
  int   done_times_s[$];

  bin2bcd_resultado #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .init(init_s), .bin(bin_s),
    .bcd(bcd_s), .sign(sign_s), .busy(busy_s), .DONE(done_s)
  );

  bin2bcd_resultado #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .init(init_u), .bin(bin_u),
    .bcd(bcd_u), .sign(sign_u), .busy(busy_u), .DONE(done_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: magnitude as an integer, digits by repeated division by ten.
  function automatic exp_t ref_conv(input logic [31:0] b, input bit signed_mode, input int acc);
    exp_t            e;
    longint unsigned mag;
    bit              neg;
    neg = signed_mode && ($signed(b) < 0);
    mag = neg ? (64'd4294967296 - longint'(b)) : longint'(b);
    e.bcd = '0;
    for (int i = 0; i < 10; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    e.sign    = neg;
    e.acc_cyc = acc;
    return e;
  endfunction

  // Monitor: pops one expectation per DONE pulse, checks busy drops a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (busy_chk_s) check("busy_after_done_s", busy_s, 0);
    if (busy_chk_u) check("busy_after_done_u", busy_u, 0);
    busy_chk_s = 0;
    busy_chk_u = 0;
    if (done_s) begin
      done_cnt_s++;
      done_times_s.push_back(cyc);
      busy_chk_s = 1;
      check("done_expected_s", q_s.size() > 0, 1);
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check("bcd_s", bcd_s, e.bcd);
        check("sign_s", sign_s, e.sign);
        if (e.acc_cyc >= 0) check("latency_s", cyc - e.acc_cyc, 64);
      end
    end
    if (done_u) begin
      busy_chk_u = 1;
      check("done_expected_u", q_u.size() > 0, 1);
      if (q_u.size() > 0) begin
        e = q_u.pop_front();
        check("bcd_u", bcd_u, e.bcd);
        check("sign_u", sign_u, e.sign);
        if (e.acc_cyc >= 0) check("latency_u", cyc - e.acc_cyc, 64);
      end
    end
  end

  task automatic start(input logic [31:0] b, input bit use_s, input bit use_u);
    @(negedge clk);
    bin_s  = use_s ? b : bin_s;
    bin_u  = use_u ? b : bin_u;
    init_s = use_s;
    init_u = use_u;
    @(posedge clk);
    #1;
    init_s = 1'b0;
    init_u = 1'b0;
    if (use_s) begin
      q_s.push_back(ref_conv(b, 1'b1, cyc));
      check("busy_on_accept_s", busy_s, 1);
    end
    if (use_u) begin
      q_u.push_back(ref_conv(b, 1'b0, cyc));
      check("busy_on_accept_u", busy_u, 1);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_s || busy_u) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", busy_s | busy_u, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] vec[4];
    logic [31:0] r;
    int          base, k;

    vec[0] = 32'h0000_0000;
    vec[1] = 32'h0000_3039;
    vec[2] = 32'hFFFF_FFFF;
    vec[3] = 32'h8000_0000;

    // Reset state
    #12;
    check("rst_bcd", bcd_s, 0);
    check("rst_sign", sign_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_bcd_u", bcd_u, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors on both instances
    foreach (vec[i]) begin
      start(vec[i], 1, 1);
      wait_idle();
    end

    // Random vectors
    for (int n = 0; n < 16; n++) begin
      r = $urandom;
      if (n % 4 == 0) r = 32'($urandom_range(0, 99999));
      start(r, 1, 1);
      wait_idle();
    end

    // init pulse with a new bin mid-conversion must be ignored
    start(32'(-999), 1, 0);
    repeat (19) @(negedge clk);
    bin_s  = 32'd7;
    init_s = 1'b1;
    @(negedge clk);
    init_s = 1'b0;
    wait_idle();
    check("hazard_hold_bcd", bcd_s, 40'h00_0000_0999);

    // Reset mid-conversion: outputs clear at once and no DONE follows
    start(32'(-999), 1, 0);
    repeat (29) @(negedge clk);
    base  = done_cnt_s;
    reset = 1'b0;
    #1;
    check("abort_bcd", bcd_s, 0);
    check("abort_sign", sign_s, 0);
    check("abort_busy", busy_s, 0);
    q_s.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", done_cnt_s - base, 0);

    // Back-to-back with init held high: multiplier product -123*456
    base = done_cnt_s;
    for (int n = 0; n < 3; n++) q_s.push_back(ref_conv(32'(-123 * 456), 1'b1, -1));
    @(negedge clk);
    bin_s  = 32'(-123 * 456);
    init_s = 1'b1;
    k = 0;
    while (done_cnt_s - base < 3 && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    init_s = 1'b0;
    check("b2b_done_count", done_cnt_s - base, 3);
    if (done_times_s.size() >= 3) begin
      check("b2b_interval_1", done_times_s[$-1] - done_times_s[$-2], 66);
      check("b2b_interval_2", done_times_s[$] - done_times_s[$-1], 66);
    end
    wait_idle();
    check("final_bcd", bcd_s, 40'h00_0005_6088);
    check("final_sign", sign_s, 1);
    check("queue_drained", q_s.size() + q_u.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
